// File: rtl/led_display_mux_ctrl.sv
// ---------------------------------------------------------------------------
// led_display_mux_ctrl
//
// Drives the game LEDs and a multiplexed bank of 7-segment digits that
// shows the current score.
//   * led  : one-cycle registered copy of (seq_led | user_input), or the
//            loss pattern while display_loss is high.
//   * score: loaded on score_valid and converted to BCD by a serial
//            double-dabble FSM (IDLE -> SHIFT x SCORE_W -> DONE). The
//            displayed digits change only in DONE, so a half-converted
//            value is never shown. A load request that arrives while busy
//            is remembered and started straight after DONE.
//   * scan : each digit is driven for SCAN_DIV cycles; an/seg are
//            registered together. Leading zeros are blanked and an
//            out-of-range score shows a dash on every digit.
//
// Optional feature: define LOSS_BLINK_EN to make the loss pattern blink
// (all-ones/all-zeros, BLINK_DIV cycles per half period). Without it the
// loss pattern is solid all-ones and BLINK_DIV is not used.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seq_led      sequence playback pattern        [N_LED]
//   user_input   button echo pattern              [N_LED]
//   display_loss game-lost level
//   score        binary score                     [SCORE_W]
//   score_valid  single-cycle score load request
//   led          LED drive, active-high           [N_LED]
//   seg          segments {g,f,e,d,c,b,a}         [7]
//   an           one-hot digit enable             [N_DIGITS]
//   busy         conversion in progress
// ---------------------------------------------------------------------------
module led_display_mux_ctrl #(
    parameter int N_LED     = 4,
    parameter int N_DIGITS  = 2,
    parameter int SCORE_W   = 7,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LED-1:0]    seq_led,
    input  logic [N_LED-1:0]    user_input,
    input  logic                display_loss,
    input  logic [SCORE_W-1:0]  score,
    input  logic                score_valid,
    output logic [N_LED-1:0]    led,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                busy
);

    // Enough BCD digits to hold any SCORE_W-bit value (3 bits < 1 decimal
    // digit), and never fewer than the displayed digits.
    localparam int NB_FULL = (SCORE_W + 2) / 3;
    localparam int NB      = (NB_FULL > N_DIGITS) ? NB_FULL : N_DIGITS;
    localparam int BCD_W   = 4 * NB;
    localparam int DISP_W  = 4 * N_DIGITS;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_reg, state_next;
    logic [SCORE_W-1:0]   bin_reg;
    logic [BCD_W-1:0]     bcd_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [SCORE_W-1:0]   score_cap_reg;
    logic                 pending_reg;
    logic                 load;
    logic [SCORE_W-1:0]   load_val;

    logic [DISP_W-1:0]    digits_reg;
    logic                 over_reg;
    logic                 over_next;

    logic [SCAN_W-1:0]    scan_cnt_reg;
    logic [IDX_W-1:0]     dig_idx_reg;
    logic [N_DIGITS-1:0]  upper_zero;

    logic [N_LED-1:0]     led_reg, loss_pattern;
    logic [6:0]           seg_reg, seg_next;
    logic [N_DIGITS-1:0]  an_reg;

    // ---------------------------------------------------------------
    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift.
    // ---------------------------------------------------------------
    logic [BCD_W-1:0] bcd_adj;
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
        // Any non-zero BCD digit above the displayed ones means overflow.
        if (NB > N_DIGITS) begin : g_over
            assign over_next = |bcd_reg[BCD_W-1:DISP_W];
        end else begin : g_no_over
            assign over_next = 1'b0;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Converter FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_val   = score;
        case (state_reg)
            IDLE: begin
                if (score_valid) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt_reg == CNT_W'(SCORE_W - 1))
                    state_next = DONE;
            end
            DONE: begin
                // Chain directly into the next conversion; a request in
                // this very cycle is newer than the captured one.
                if (pending_reg || score_valid) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                    load_val   = score_valid ? score : score_cap_reg;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            bit_cnt_reg   <= '0;
            score_cap_reg <= '0;
            pending_reg   <= 1'b0;
            digits_reg    <= '0;
            over_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                bin_reg     <= load_val;
                bcd_reg     <= '0;
                bit_cnt_reg <= '0;
            end else if (state_reg == SHIFT) begin
                bin_reg     <= bin_reg << 1;
                bcd_reg     <= {bcd_adj[BCD_W-2:0], bin_reg[SCORE_W-1]};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (load)
                pending_reg <= 1'b0;
            else if (score_valid && busy)
                pending_reg <= 1'b1;
            if (score_valid && busy)
                score_cap_reg <= score;
            // All displayed digits change together, only on a finished result.
            if (state_reg == DONE) begin
                digits_reg <= bcd_reg[DISP_W-1:0];
                over_reg   <= over_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Display scan
    // ---------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // upper_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            acc           = acc & (digits_reg[4*i +: 4] == 4'd0);
            upper_zero[i] = acc;
        end
    end

    always_comb begin
        seg_next = seg_decode(digits_reg[4*dig_idx_reg +: 4]);
        if (over_reg)
            seg_next = 7'b1000000;
        else if ((dig_idx_reg != '0) && upper_zero[dig_idx_reg])
            seg_next = 7'b0000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            dig_idx_reg  <= '0;
            an_reg       <= N_DIGITS'(1);
            seg_reg      <= 7'b0111111;
        end else begin
            if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_reg <= '0;
                dig_idx_reg  <= (dig_idx_reg == IDX_W'(N_DIGITS - 1)) ?
                                '0 : dig_idx_reg + 1'b1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
            an_reg  <= N_DIGITS'(1) << dig_idx_reg;
            seg_reg <= seg_next;
        end
    end

    // ---------------------------------------------------------------
    // LED drive
    // ---------------------------------------------------------------
`ifdef LOSS_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    logic               loss_d_reg;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               blink_on_reg, blink_on_next;

    // A rising display_loss restarts the blink in the all-ones phase.
    always_comb begin
        blink_cnt_next = '0;
        blink_on_next  = 1'b1;
        if (display_loss && loss_d_reg) begin
            if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_next = '0;
                blink_on_next  = ~blink_on_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
                blink_on_next  = blink_on_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_d_reg    <= 1'b0;
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else begin
            loss_d_reg    <= display_loss;
            blink_cnt_reg <= blink_cnt_next;
            blink_on_reg  <= blink_on_next;
        end
    end

    assign loss_pattern = {N_LED{blink_on_next}};
`else
    assign loss_pattern = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led_reg <= '0;
        else
            led_reg <= display_loss ? loss_pattern : (seq_led | user_input);
    end

    assign led = led_reg;
    assign seg = seg_reg;
    assign an  = an_reg;

endmodule
